// File: rtl/fetch_bram_wbi_top.sv
// Purpose: W/B/I buffer BRAM (32-bit write port A, DATA_WIDTH read port B) plus a tile fetch controller.
// Latency: addresses start 1 cycle after start_fetch; doutb is 1 cycle behind addrb; fetch_done 2 cycles after last address.
// Backpressure: none; a tile streams one word per cycle once started, and start/clear are ignored outside IDLE.
module fetch_bram_wbi_top #(
    parameter int ADDR_WIDTH       = 16,
    parameter int ORIGINAL_COLUMNS = 768,
    parameter int ORIGINAL_ROWS    = 512,
    parameter int NUM_BITS         = 8,
    parameter int DATA_WIDTH       = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_fetch,
    input  logic                  reset_addr_counter,
    input  logic [2:0]            Buffer_Select,
    input  logic                  Tiles_Control,
    input  logic                  wea,
    input  logic                  ena,
    input  logic [13:0]           addra,
    input  logic [31:0]           dina,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic [ADDR_WIDTH-1:0] addrb
);

    localparam int DEPTH = 2048;
    localparam logic [ADDR_WIDTH-1:0] W_BASE = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] B_BASE = ADDR_WIDTH'(1024);
    localparam logic [ADDR_WIDTH-1:0] I_BASE = ADDR_WIDTH'(512);

    // Lane mapping assumes 8 x 32-bit lanes per read word and at least 11 address bits.
    generate
        if (DATA_WIDTH != 256 || ADDR_WIDTH < 11 || (DATA_WIDTH % NUM_BITS) != 0 ||
            ORIGINAL_COLUMNS < 1 || ORIGINAL_ROWS < 1) begin : g_bad_params
            $error("fetch_bram_wbi_top: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] base;
    logic [9:0]            beat;
    logic                  tile_long;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [9:0]            tile_len;

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra[13:3]][{addra[2:0], 5'd0} +: 32] <= dina;
        end
    end

    // Non-blocking read gives old data on a same-word read-during-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= '0;
        end else begin
            doutb <= mem[addrb[10:0]];
        end
    end

    always_comb begin
        sel_valid = 1'b1;
        sel_base  = W_BASE;
        case (Buffer_Select)
            3'b000:  sel_base = W_BASE;
            3'b001:  sel_base = B_BASE;
            3'b010:  sel_base = I_BASE;
            default: sel_valid = 1'b0;
        endcase
    end

    assign tile_len = tile_long ? 10'd512 : 10'd32;

    // cnt is deliberately kept across tiles so the next fetch resumes where this one stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            base       <= '0;
            beat       <= '0;
            tile_long  <= 1'b0;
            addrb      <= '0;
            fetch_done <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (reset_addr_counter) begin
                        cnt <= '0;
                    end else if (start_fetch && sel_valid) begin
                        state     <= FETCH;
                        beat      <= '0;
                        base      <= sel_base;
                        tile_long <= ~Tiles_Control;
                    end
                end
                FETCH: begin
                    if (beat == tile_len) begin
                        state <= LAST;
                    end else begin
                        addrb <= base + cnt;
                        cnt   <= cnt + 1'b1;
                        beat  <= beat + 1'b1;
                    end
                end
                LAST: begin
                    state      <= DONE;
                    fetch_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_bram_wbi_top.sv
// Scoreboard bench for fetch_bram_wbi_top: stimulus pushes cycle-stamped expected addrb/doutb/fetch_done,
// a negedge monitor pops and compares them.
module tb_fetch_bram_wbi_top;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_fetch;
    logic         reset_addr_counter;
    logic [2:0]   Buffer_Select;
    logic         Tiles_Control;
    logic         wea;
    logic         ena;
    logic [13:0]  addra;
    logic [31:0]  dina;
    logic         fetch_done;
    logic [255:0] doutb;
    logic [15:0]  addrb;

    fetch_bram_wbi_top dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_fetch        (start_fetch),
        .reset_addr_counter (reset_addr_counter),
        .Buffer_Select      (Buffer_Select),
        .Tiles_Control      (Tiles_Control),
        .wea                (wea),
        .ena                (ena),
        .addra              (addra),
        .dina               (dina),
        .fetch_done         (fetch_done),
        .doutb              (doutb),
        .addrb              (addrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [255:0] val;
    } exp_t;

    exp_t addr_q[$];
    exp_t data_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Written pattern: write word a holds 2a+2, so read word k lane j holds 16k+2j+2 (words 0..1135).
    function automatic logic [255:0] exp_word(input int k);
        logic [255:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            w[32*j +: 32] = (k < 1136) ? 32'(16*k + 2*j + 2) : 32'd0;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (addr_q.size() > 0 && addr_q[0].cyc <= cyc) begin
            e = addr_q.pop_front();
            check("addrb", {240'd0, addrb}, e.val);
        end
        while (data_q.size() > 0 && data_q[0].cyc <= cyc) begin
            e = data_q.pop_front();
            check("doutb", doutb, e.val);
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            check("fetch_done_pulse", {255'd0, fetch_done}, 256'd1);
        end else begin
            check("fetch_done_quiet", {255'd0, fetch_done}, 256'd0);
        end
    end

    task automatic run_tile(input logic [2:0] sel, input logic tc, input int base, input int cnt0);
        int s;
        int tlen;
        int a;
        tlen = tc ? 32 : 512;
        @(negedge clk);
        Buffer_Select = sel;
        Tiles_Control = tc;
        start_fetch   = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_fetch = 1'b0;
        for (int i = 1; i <= tlen; i++) begin
            a = (base + cnt0 + i - 1) % 65536;
            addr_q.push_back('{s + i, 256'(a)});
            data_q.push_back('{s + i + 1, exp_word(a % 2048)});
        end
        done_q.push_back(s + tlen + 2);
        last_addr = (base + cnt0 + tlen - 1) % 65536;
        repeat (tlen + 5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d got no finish expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        start_fetch = 1'b0;
        reset_addr_counter = 1'b0;
        Buffer_Select = 3'b000;
        Tiles_Control = 1'b1;
        wea = 1'b0;
        ena = 1'b0;
        addra = '0;
        dina = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_addrb", {240'd0, addrb}, 256'd0);
        check("reset_doutb", doutb, 256'd0);
        check("reset_fetch_done", {255'd0, fetch_done}, 256'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9088; i++) begin
            @(negedge clk);
            ena = 1'b1;
            wea = 1'b1;
            addra = i[13:0];
            dina = 32'(2*i + 2);
        end
        @(negedge clk);
        ena = 1'b0;
        wea = 1'b0;

        // W tile from a cleared counter, then a second W tile continuing at 32.
        reset_addr_counter = 1'b1;
        @(negedge clk);
        reset_addr_counter = 1'b0;
        run_tile(3'b000, 1'b1, 0, 0);
        run_tile(3'b000, 1'b1, 0, 32);

        // start_fetch alongside reset_addr_counter: counter clears, fetch is ignored.
        @(negedge clk);
        Buffer_Select = 3'b010;
        Tiles_Control = 1'b0;
        reset_addr_counter = 1'b1;
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        repeat (3) @(negedge clk);
        reset_addr_counter = 1'b0;
        repeat (3) @(negedge clk);
        check("clear_ignores_start", {240'd0, addrb}, 256'(last_addr));

        run_tile(3'b010, 1'b0, 512, 0);

        // Invalid region: nothing moves and no done pulse.
        @(negedge clk);
        Buffer_Select = 3'b111;
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        repeat (8) @(negedge clk);
        check("invalid_sel_addrb", {240'd0, addrb}, 256'(last_addr));

        // Counter persists across a region change.
        run_tile(3'b000, 1'b1, 0, 512);

        // Abort a long W tile with an asynchronous reset mid-fetch.
        @(negedge clk);
        Buffer_Select = 3'b000;
        Tiles_Control = 1'b0;
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_addrb", {240'd0, addrb}, 256'd0);
        check("abort_doutb", doutb, 256'd0);
        check("abort_fetch_done", {255'd0, fetch_done}, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_tile(3'b001, 1'b1, 1024, 0);

        repeat (4) @(negedge clk);
        check("addr_q_drained", 256'(addr_q.size()), 256'd0);
        check("data_q_drained", 256'(data_q.size()), 256'd0);
        check("done_q_drained", 256'(done_q.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_bram_wbi_top.md
Name: fetch_bram_wbi_top

Overview:
- Top-level fetch path for the BERT accelerator's weight (W), bias (B) and input (I) buffers.
- Contains one simple dual-port BRAM:
  - Port A: 32-bit write port, used by the host/loader.
  - Port B: DATA_WIDTH-bit read port.
- Contains a fetch controller that streams a tile of consecutive read words from the selected buffer region to the systolic array feed.
- The read address counter persists across fetches, so successive tiles continue where the last one ended.

Parameters:
- ADDR_WIDTH, 16: width of the read address counter and of addrb.
- ORIGINAL_COLUMNS, 768: source matrix columns before transpose. Informational only; no effect on addressing.
- ORIGINAL_ROWS, 512: source matrix rows before transpose. Informational only.
- NUM_BITS, 8: element width. DATA_WIDTH/NUM_BITS = 32 elements per read word.
- DATA_WIDTH, 256: read word width. Equals 8 write words of 32 bits.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_fetch  in  1  level sampled at the edge; starts a tile fetch when the controller is IDLE.
- reset_addr_counter  in  1  clears the address counter; honoured only while IDLE.
- Buffer_Select  in  3  region select: 000 = W, 001 = B, 010 = I. Other codes are invalid.
- Tiles_Control  in  1  tile length: 1 = 32 read words, 0 = 512 read words.
- wea  in  1  port-A write enable.
- ena  in  1  port-A enable.
- addra  in  14  port-A word address, 32-bit granularity.
- dina  in  32  port-A write data.
- fetch_done  out  1  single-cycle pulse at the end of a tile.
- doutb  out  DATA_WIDTH  read data.
- addrb  out  ADDR_WIDTH  current read address driven to the BRAM.

Behaviour:
- Memory geometry:
  - Depth 2048 read words, equivalently 16384 write words.
  - Contents are not cleared by reset; they initialise to zero.
- Port A write:
  - When ena && wea at a rising edge, write dina into lane addra[2:0] (bits 32*lane+31 : 32*lane) of read word addra[13:3].
  - Port A has no read path.
  - Writes are allowed at any time, including during a fetch.
- Port B read:
  - doutb <= mem[addrb mod 2048], registered, 1-cycle latency.
  - Read-during-write to the same word returns the old data.
- Region bases (localparams), in read words: W_BASE = 0, B_BASE = 1024, I_BASE = 512.
  - The base is latched from Buffer_Select when the fetch starts.
  - TILE (32 or 512) is latched from Tiles_Control at the same time.
- Controller states: IDLE, FETCH, LAST, DONE.
- IDLE:
  - If reset_addr_counter = 1, cnt <= 0 and start_fetch is ignored that cycle.
  - Else if start_fetch = 1 and Buffer_Select is valid, go to FETCH and clear the beat counter.
  - An invalid Buffer_Select ignores start_fetch; the controller stays in IDLE and fetch_done is never asserted.
- FETCH:
  - Each cycle: addrb <= base + cnt (truncated to ADDR_WIDTH, wraps), cnt <= cnt + 1, beat <= beat + 1.
  - After TILE addresses have been issued, go to LAST.
  - start_fetch and reset_addr_counter are ignored while in FETCH.
- LAST: one cycle to cover BRAM latency, so doutb now holds the last word of the tile. Go to DONE.
- DONE: fetch_done = 1 for exactly this one cycle, then return to IDLE.
- Net timing: addresses appear on TILE consecutive cycles starting 1 cycle after start_fetch is sampled. fetch_done pulses 2 cycles after the last address is issued.
- cnt is not cleared at the end of a fetch. The next fetch continues from the same cnt, even when a different region is selected, unless reset_addr_counter was applied in IDLE.
- A reset_addr_counter level held high into FETCH (via start_fetch in the same IDLE cycle) has no effect; start_fetch wins only when reset_addr_counter = 0.
- Reset, asynchronous on rst_n low, mid-operation included:
  - state = IDLE, cnt = 0, addrb = 0, doutb = 0, fetch_done = 0.
  - Any fetch in progress is aborted.

Test Plan:
- Reset, then write addra 0..9087 with dina = 2*addra+2 -> read word k, lane j holds 16k+2j+2.
- Buffer_Select = 000, Tiles_Control = 1, reset_addr_counter pulsed, start_fetch pulsed -> addrb 0..31 on 32 consecutive cycles. doutb lane 0 goes 2, 18, ..., 498, with lane 7 of word 31 = 512. fetch_done pulses once.
- Then Buffer_Select = 010, Tiles_Control = 0, reset_addr_counter held at 1, start_fetch pulsed. start_fetch is ignored while reset_addr_counter = 1; release reset_addr_counter (or hold it and observe the ignore) and pulse start_fetch again with reset_addr_counter = 0 -> addrb 512..1023, doutb word 512 lane 0 = 8194, fetch_done pulses once after 512 beats.
- Second W tile without reset_addr_counter -> addrb continues 32..63.
- Buffer_Select = 111 with start_fetch -> addrb unchanged, fetch_done stays 0.
- rst_n low mid-FETCH -> all outputs 0 immediately. A fresh fetch restarts at base + 0.
